// File: rtl/ctrl_pkg.sv
// Shared control encodings for the 5-stage core: opcodes, extender/result/ALU
// selects, and the per-stage control bundles carried down the pipeline.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
    logic       illegal;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_w_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-stage inputs and per-stage control outputs of the pipelined control unit.
interface ctrl_pipe_if;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic       funct7b5D;
  logic       FlushE;
  logic       ZeroE;
  logic [2:0] ImmSrcD;
  logic       IllegalD;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
  logic       MemWriteM;
  logic       ALUSrcE;
  logic [2:0] ALUControlE;
  logic       PCSrcE;
  logic       IllegalE;

  modport master (
    output opD, funct3D, funct7b5D, FlushE, ZeroE,
    input  ImmSrcD, IllegalD, RegWriteE, RegWriteM, RegWriteW,
           ResultSrcE, ResultSrcM, ResultSrcW, MemWriteM, ALUSrcE,
           ALUControlE, PCSrcE, IllegalE
  );

  modport slave (
    input  opD, funct3D, funct7b5D, FlushE, ZeroE,
    output ImmSrcD, IllegalD, RegWriteE, RegWriteM, RegWriteW,
           ResultSrcE, ResultSrcM, ResultSrcW, MemWriteM, ALUSrcE,
           ALUControlE, PCSrcE, IllegalE
  );
endinterface

// File: rtl/ctrl_pipe_alu_dec.sv
// ALU decoder: ALUOp plus funct fields to ALU operation; flags unsupported funct3.
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALUC_ADD;
    illegal     = 1'b0;
    unique case (alu_op)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  alu_control = ALUC_SLT;
          3'b110:  alu_control = ALUC_OR;
          3'b111:  alu_control = ALUC_AND;
          default: illegal = 1'b1;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: Decode-stage main decoder plus D->E->M->W control registers.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  ctrl_pipe_if.slave  bus
);

  logic       reg_write_raw, alu_src_raw, mem_write_raw, branch_raw, jump_raw;
  logic [2:0] imm_src_raw;
  logic [1:0] result_src_raw, alu_op;
  logic       op_known, alu_illegal, illegal_d;
  logic [2:0] alu_control_d;
  ctrl_e_t    ctrl_d, ctrl_e;
  ctrl_m_t    ctrl_m;
  ctrl_w_t    ctrl_w;

  always_comb begin
    reg_write_raw  = 1'b0;
    imm_src_raw    = IMM_I;
    alu_src_raw    = 1'b0;
    mem_write_raw  = 1'b0;
    result_src_raw = RES_ALU;
    branch_raw     = 1'b0;
    jump_raw       = 1'b0;
    alu_op         = ALUOP_ADD;
    op_known       = 1'b1;
    unique case (bus.opD)
      OP_LOAD:  begin reg_write_raw = 1'b1; alu_src_raw = 1'b1; result_src_raw = RES_MEM; end
      OP_STORE: begin imm_src_raw = IMM_S; alu_src_raw = 1'b1; mem_write_raw = 1'b1; end
      OP_R:     begin reg_write_raw = 1'b1; alu_op = ALUOP_FUNCT; end
      OP_BEQ:   begin imm_src_raw = IMM_B; branch_raw = 1'b1; alu_op = ALUOP_SUB; end
      OP_IALU:  begin reg_write_raw = 1'b1; alu_src_raw = 1'b1; alu_op = ALUOP_FUNCT; end
      OP_JAL:   begin reg_write_raw = 1'b1; imm_src_raw = IMM_J; result_src_raw = RES_PC4; jump_raw = 1'b1; end
      OP_LUI:   begin reg_write_raw = 1'b1; imm_src_raw = IMM_U; result_src_raw = RES_IMM; end
      default:  op_known = 1'b0;
    endcase
  end

  alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3D),
    .op5         (bus.opD[5]),
    .funct7b5    (bus.funct7b5D),
    .alu_control (alu_control_d),
    .illegal     (alu_illegal)
  );

  assign illegal_d = ~op_known | alu_illegal;

  // Illegal instructions become an inert bundle that still carries the illegal flag.
  always_comb begin
    ctrl_d = '0;
    if (illegal_d) begin
      ctrl_d.illegal = 1'b1;
    end else begin
      ctrl_d.reg_write   = reg_write_raw;
      ctrl_d.result_src  = result_src_raw;
      ctrl_d.mem_write   = mem_write_raw;
      ctrl_d.jump        = jump_raw;
      ctrl_d.branch      = branch_raw;
      ctrl_d.alu_control = alu_control_d;
      ctrl_d.alu_src     = alu_src_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e <= '0;
      ctrl_m <= '0;
      ctrl_w <= '0;
    end else begin
      ctrl_e <= bus.FlushE ? '0 : ctrl_d;
      ctrl_m <= '{reg_write: ctrl_e.reg_write, result_src: ctrl_e.result_src,
                  mem_write: ctrl_e.mem_write};
      ctrl_w <= '{reg_write: ctrl_m.reg_write, result_src: ctrl_m.result_src};
    end
  end

  assign bus.ImmSrcD     = illegal_d ? IMM_I : imm_src_raw;
  assign bus.IllegalD    = illegal_d;
  assign bus.RegWriteE   = ctrl_e.reg_write;
  assign bus.ResultSrcE  = ctrl_e.result_src;
  assign bus.ALUSrcE     = ctrl_e.alu_src;
  assign bus.ALUControlE = ctrl_e.alu_control;
  assign bus.IllegalE    = ctrl_e.illegal;
  assign bus.PCSrcE      = ctrl_e.jump | (ctrl_e.branch & bus.ZeroE);
  assign bus.RegWriteM   = ctrl_m.reg_write;
  assign bus.ResultSrcM  = ctrl_m.result_src;
  assign bus.MemWriteM   = ctrl_m.mem_write;
  assign bus.RegWriteW   = ctrl_w.reg_write;
  assign bus.ResultSrcW  = ctrl_w.result_src;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: decode vector table plus multi-cycle pipeline sequences.
module tb_ctrl_pipe;

  logic clk = 1'b0;
  logic reset;
  int unsigned total = 0;
  int unsigned bad   = 0;

  ctrl_pipe_if bus ();

  ctrl_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       flush;
    logic       zero;
    logic [2:0] imm_d;
    logic       ill_d;
    logic       rw_e;
    logic [1:0] rs_e;
    logic       src_e;
    logic [2:0] aluc_e;
    logic       pc_e;
    logic       ill_e;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic flush);
    @(negedge clk);
    bus.opD       = op;
    bus.funct3D   = f3;
    bus.funct7b5D = f7;
    bus.FlushE    = flush;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pipe;
    @(negedge clk);
    reset     = 1'b1;
    bus.ZeroE = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, " RegWriteE"},   8'(bus.RegWriteE),   8'd0);
    chk({tag, " RegWriteM"},   8'(bus.RegWriteM),   8'd0);
    chk({tag, " RegWriteW"},   8'(bus.RegWriteW),   8'd0);
    chk({tag, " ResultSrcE"},  8'(bus.ResultSrcE),  8'd0);
    chk({tag, " ResultSrcM"},  8'(bus.ResultSrcM),  8'd0);
    chk({tag, " ResultSrcW"},  8'(bus.ResultSrcW),  8'd0);
    chk({tag, " MemWriteM"},   8'(bus.MemWriteM),   8'd0);
    chk({tag, " ALUSrcE"},     8'(bus.ALUSrcE),     8'd0);
    chk({tag, " ALUControlE"}, 8'(bus.ALUControlE), 8'd0);
    chk({tag, " IllegalE"},    8'(bus.IllegalE),    8'd0);
    chk({tag, " PCSrcE"},      8'(bus.PCSrcE),      8'd0);
  endtask

  initial begin
    //                op          f3      f7    fl    z     immD  illD  rwE   rsE    srcE  alucE   pcE   illE
    vecs[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[2]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[3]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[4]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0};
    vecs[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00, 1'b0, 3'b011, 1'b0, 1'b0};
    vecs[6]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00, 1'b0, 3'b101, 1'b0, 1'b0};
    vecs[7]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[8]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00, 1'b1, 3'b101, 1'b0, 1'b0};
    vecs[9]  = '{7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[10] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 3'b001, 1'b1, 1'b0};
    vecs[11] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[12] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 2'b10, 1'b0, 3'b000, 1'b1, 1'b0};
    vecs[13] = '{7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[14] = '{7'b1111111, 3'b111, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[15] = '{7'b0000011, 3'b010, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[16] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};

    reset = 1'b1;
    bus.opD = 7'd0; bus.funct3D = 3'd0; bus.funct7b5D = 1'b0;
    bus.FlushE = 1'b0; bus.ZeroE = 1'b0;
    tick();
    tick();
    chk_clear("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].flush);
      bus.ZeroE = 1'b0;
      #1;
      chk($sformatf("v%0d ImmSrcD", i),  8'(bus.ImmSrcD),  8'(vecs[i].imm_d));
      chk($sformatf("v%0d IllegalD", i), 8'(bus.IllegalD), 8'(vecs[i].ill_d));
      tick();
      bus.FlushE = 1'b0;
      bus.ZeroE  = vecs[i].zero;
      #1;
      chk($sformatf("v%0d RegWriteE", i),   8'(bus.RegWriteE),   8'(vecs[i].rw_e));
      chk($sformatf("v%0d ResultSrcE", i),  8'(bus.ResultSrcE),  8'(vecs[i].rs_e));
      chk($sformatf("v%0d ALUSrcE", i),     8'(bus.ALUSrcE),     8'(vecs[i].src_e));
      chk($sformatf("v%0d ALUControlE", i), 8'(bus.ALUControlE), 8'(vecs[i].aluc_e));
      chk($sformatf("v%0d PCSrcE", i),      8'(bus.PCSrcE),      8'(vecs[i].pc_e));
      chk($sformatf("v%0d IllegalE", i),    8'(bus.IllegalE),    8'(vecs[i].ill_e));
    end

    // Reset held two cycles over a lw/sw/jal stream clears everything in flight.
    reset_pipe();
    drive(7'b0000011, 3'b010, 1'b0, 1'b0); tick();
    drive(7'b0100011, 3'b010, 1'b0, 1'b0); tick();
    drive(7'b1101111, 3'b000, 1'b0, 1'b0); tick();
    chk("pre-reset PCSrcE", 8'(bus.PCSrcE), 8'd1);
    chk("pre-reset MemWriteM", 8'(bus.MemWriteM), 8'd1);
    chk("pre-reset RegWriteW", 8'(bus.RegWriteW), 8'd1);
    drive(7'b0000011, 3'b010, 1'b0, 1'b0);
    reset = 1'b1;
    bus.ZeroE = 1'b1;
    tick();
    chk_clear("mid-reset1");
    drive(7'b0100011, 3'b010, 1'b0, 1'b0);
    tick();
    chk_clear("mid-reset2");
    drive(7'b1111111, 3'b000, 1'b0, 1'b0);
    reset = 1'b0;
    bus.ZeroE = 1'b0;

    // sw reaches M two cycles after D.
    reset_pipe();
    drive(7'b0100011, 3'b010, 1'b0, 1'b0);
    #1 chk("sw ImmSrcD", 8'(bus.ImmSrcD), 8'd1);
    tick();
    drive(7'b1111111, 3'b000, 1'b0, 1'b0); tick();
    chk("sw MemWriteM", 8'(bus.MemWriteM), 8'd1);
    chk("sw RegWriteM", 8'(bus.RegWriteM), 8'd0);

    // R-type sub through to W.
    reset_pipe();
    drive(7'b0110011, 3'b000, 1'b1, 1'b0); tick();
    chk("sub ALUControlE", 8'(bus.ALUControlE), 8'b001);
    chk("sub ALUSrcE", 8'(bus.ALUSrcE), 8'd0);
    drive(7'b1111111, 3'b000, 1'b0, 1'b0); tick();
    tick();
    chk("sub RegWriteW", 8'(bus.RegWriteW), 8'd1);
    chk("sub ResultSrcW", 8'(bus.ResultSrcW), 8'b00);

    // jal: immediate redirect and PC+4 writeback.
    reset_pipe();
    drive(7'b1101111, 3'b000, 1'b0, 1'b0);
    #1 chk("jal ImmSrcD", 8'(bus.ImmSrcD), 8'd3);
    tick();
    chk("jal PCSrcE", 8'(bus.PCSrcE), 8'd1);
    drive(7'b1111111, 3'b000, 1'b0, 1'b0); tick();
    tick();
    chk("jal ResultSrcW", 8'(bus.ResultSrcW), 8'b10);
    chk("jal RegWriteW", 8'(bus.RegWriteW), 8'd1);

    // add then flushed lw: add writes back, the bubble does not.
    reset_pipe();
    drive(7'b0110011, 3'b000, 1'b0, 1'b0); tick();
    drive(7'b0000011, 3'b010, 1'b0, 1'b1); tick();
    chk("flush RegWriteE", 8'(bus.RegWriteE), 8'd0);
    chk("flush ResultSrcE", 8'(bus.ResultSrcE), 8'b00);
    chk("flush add RegWriteM", 8'(bus.RegWriteM), 8'd1);
    drive(7'b1111111, 3'b000, 1'b0, 1'b0); tick();
    chk("flush add RegWriteW", 8'(bus.RegWriteW), 8'd1);
    chk("flush RegWriteM", 8'(bus.RegWriteM), 8'd0);
    tick();
    chk("flush RegWriteW", 8'(bus.RegWriteW), 8'd0);
    chk("flush ResultSrcW", 8'(bus.ResultSrcW), 8'b00);

    // Illegal opcode never enables a write downstream.
    reset_pipe();
    drive(7'b1111111, 3'b000, 1'b0, 1'b0);
    #1 chk("ill IllegalD", 8'(bus.IllegalD), 8'd1);
    tick();
    chk("ill IllegalE", 8'(bus.IllegalE), 8'd1);
    tick();
    chk("ill RegWriteM", 8'(bus.RegWriteM), 8'd0);
    chk("ill MemWriteM", 8'(bus.MemWriteM), 8'd0);
    tick();
    chk("ill RegWriteW", 8'(bus.RegWriteW), 8'd0);

    // lui writes the immediate.
    reset_pipe();
    drive(7'b0110111, 3'b000, 1'b0, 1'b0);
    #1 chk("lui ImmSrcD", 8'(bus.ImmSrcD), 8'd4);
    tick();
    drive(7'b1111111, 3'b000, 1'b0, 1'b0); tick();
    tick();
    chk("lui ResultSrcW", 8'(bus.ResultSrcW), 8'b11);
    chk("lui RegWriteW", 8'(bus.RegWriteW), 8'd1);

    // Taken branch in E resolves while the D instruction is flushed.
    reset_pipe();
    drive(7'b1100011, 3'b000, 1'b0, 1'b0); tick();
    drive(7'b0000011, 3'b010, 1'b0, 1'b1);
    bus.ZeroE = 1'b1;
    #1 chk("br+flush PCSrcE", 8'(bus.PCSrcE), 8'd1);
    tick();
    chk("br+flush next PCSrcE", 8'(bus.PCSrcE), 8'd0);
    chk("br+flush next RegWriteE", 8'(bus.RegWriteE), 8'd0);
    chk("br+flush next ResultSrcE", 8'(bus.ResultSrcE), 8'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the 5-stage RISC-V core. Decodes the instruction held in the Decode stage, drives `ImmSrcD` to the immediate extender and the other Decode-stage selects, and carries the remaining control bits through E/M/W pipeline registers. It honours the hazard unit's `FlushE` and produces `PCSrcE` for the fetch mux.

## Interface
- No parameters; encodings are fixed in the shared package.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `opD`  in  7  `InstrD[6:0]`
- `funct3D`  in  3  `InstrD[14:12]`
- `funct7b5D`  in  1  `InstrD[30]`
- `FlushE`  in  1  bubble insert into the E stage (hazard unit)
- `ZeroE`  in  1  ALU zero flag, E stage
- `ImmSrcD`  out  3  extender select: 0=I, 1=S, 2=B, 3=J, 4=U
- `IllegalD`  out  1  unsupported opcode/funct3 in D
- `RegWriteE`, `RegWriteM`, `RegWriteW`  out  1 each
- `ResultSrcE` (hazard load detect), `ResultSrcM`, `ResultSrcW`  out  2 each: 00=ALU, 01=mem, 10=PC+4, 11=ImmExt
- `MemWriteM`  out  1
- `ALUSrcE`  out  1  1=ImmExt operand
- `ALUControlE`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `PCSrcE`  out  1  take branch/jump target
- `IllegalE`  out  1  registered `IllegalD`

## Operation
- Main decode (combinational, D) sets RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp:
  - lw 0000011: 1, I, 1, 0, 01, 0, 0, 00
  - sw 0100011: 0, S, 1, 1, 00, 0, 0, 00
  - R 0110011: 1, I, 0, 0, 00, 0, 0, 10
  - beq 1100011: 0, B, 0, 0, 00, 1, 0, 01
  - I-ALU 0010011: 1, I, 1, 0, 00, 0, 0, 10
  - jal 1101111: 1, J, 0, 0, 10, 0, 1, 00
  - lui 0110111: 1, U, 0, 0, 11, 0, 0, 00
- ALU decode: ALUOp 00→add, 01→sub; 10 by funct3: 000→sub if `opD[5]&funct7b5D`, else add; 010→slt; 110→or; 111→and.
- Any other opcode, or ALUOp 10 with another funct3: `IllegalD`=1, all write/branch/jump enables 0, ImmSrcD=0, ALUControl=add.
- D→E register: RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, Illegal. E→M: RegWrite, ResultSrc, MemWrite. M→W: RegWrite, ResultSrc.
- `PCSrcE = JumpE | (BranchE & ZeroE)`, combinational from E registers.

## Timing
- D outputs combinational, zero latency; an instruction's E/M/W controls appear 1/2/3 cycles after it is in D.
- `reset`: every register clears to 0 on the next edge; all registered outputs 0, `PCSrcE`=0. Reset mid-stream drops all in-flight control.
- `FlushE`=1: D→E register loads 0 (bubble: no write, no branch); E→M and M→W advance normally. Reset has priority over FlushE.
- No stall input: the hazard unit holds D via the IF/ID register; E always advances.
- `FlushE` together with a taken branch in E: the branch still resolves (`PCSrcE` from current E), the incoming D instruction is discarded.

## Structure
- Package `ctrl_pkg`: opcode constants, ImmSrc, ResultSrc, ALUOp and ALUControl localparams (shared with the extender and ALU).
- Sub-module `alu_dec` (ALUOp, funct3, op5, funct7b5 → ALUControl, illegal flag); main decoder and pipeline registers in `ctrl_pipe`.

## Test plan
- Reset asserted 2 cycles during lw/sw stream → all E/M/W outputs 0, `PCSrcE`=0 the cycle after.
- opD=0100011 (sw) → ImmSrcD=1 immediately; 2 cycles later MemWriteM=1, RegWriteM=0.
- opD=0110011, funct3=000, funct7b5=1 → next cycle ALUControlE=001, ALUSrcE=0; RegWriteW=1 three cycles after D.
- beq in D, then ZeroE=1 → PCSrcE=1; same with ZeroE=0 → PCSrcE=0; jal (ImmSrcD=3) → PCSrcE=1, ResultSrcW=10.
- lw in D with FlushE=1 → RegWriteE=0, ResultSrcE=00, bubble propagates to W with RegWriteW=0.
- opD=1111111 → IllegalD=1, ImmSrcD=0, IllegalE=1 next cycle, no write enable at any stage; lui → ImmSrcD=4, ResultSrcW=11.
